uart_tx_engine: RTL

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_parity.sv | 14 +
 rtl/uart_tx_engine.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned DATA_WIDTH_MIN = 5;
    localparam int unsigned DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity generator: even or odd parity over a data word.
module uart_tx_parity
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one clock per bit, optional parity, one or two stop bits,
// back-to-back frames accepted in the final stop cycle.
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DATA_ACK
);

    localparam int unsigned     CW      = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LastBit = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]   CntOne  = CW'(1);

    uart_tx_state_e        state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic                  par_bit;
    logic                  last_stop;
    logic                  accept;

    // The shift register rotates, so its XOR always equals the captured word's XOR.
    uart_tx_parity #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data   (shift_q),
        .par_typ(par_typ_q),
        .par_bit(par_bit)
    );

    assign last_stop = (state_q == STOP) && (stop_cnt_q || !stop2_q);
    assign accept    = DATA_VALID && ((state_q == IDLE) || last_stop);

    always_comb begin
        state_d    = IDLE;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        ack_d      = 1'b0;

        if (accept) begin
            state_d   = START;
            shift_d   = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            stop2_d   = STOP2;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            ack_d     = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                START: begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = {shift_q[0], shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                end
                DATA: begin
                    busy_d = 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        stop_cnt_d = 1'b0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        state_d   = DATA;
                        tx_d      = shift_q[0];
                        shift_d   = {shift_q[0], shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + CntOne;
                    end
                end
                PARITY: begin
                    state_d    = STOP;
                    busy_d     = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                STOP: begin
                    if (!last_stop) begin
                        state_d    = STOP;
                        busy_d     = 1'b1;
                        stop_cnt_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    assign TX_OUT   = tx_q;
    assign BUSY     = busy_q;
    assign DATA_ACK = ack_q;

endmodule
